// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions for the instruction decode stage: group codes,
// field positions, the decoded-bundle struct, pair functions and word decoder.
package pkg_instr_dec;

  localparam logic [2:0] GRP_UNKNOWN = 3'd0;
  localparam logic [2:0] GRP_1       = 3'd1;
  localparam logic [2:0] GRP_2       = 3'd2;
  localparam logic [2:0] GRP_3       = 3'd3;
  localparam logic [2:0] GRP_4       = 3'd4;
  localparam logic [2:0] GRP_5       = 3'd5;

  localparam int G1_OPC_LSB = 12;
  localparam int G1_RA_LSB  = 8;
  localparam int G2_OPC_LSB = 8;
  localparam int G2_RA_LSB  = 4;
  localparam int G2_RB_LSB  = 0;
  localparam int G3_OPC_LSB = 10;
  localparam int G3_RA_LSB  = 6;
  localparam int G3_RB_LSB  = 3;
  localparam int G3_RC_LSB  = 0;
  localparam int G4_OPC_LSB = 8;
  localparam int G5_OPC_LSB = 7;
  localparam int G5_RA_LSB  = 3;
  localparam int G5_RB_LSB  = 0;

  typedef struct packed {
    logic [2:0]  group;
    logic [5:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        ra_pair;
    logic        rb_pair;
    logic [15:0] imm;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
  } dec_bundle_t;

  // Register pairs are selected by opcode patterns that differ per group.
  function automatic logic ra_is_pair(input logic [2:0] grp, input logic [5:0] opc);
    logic p;
    p = 1'b0;
    case (grp)
      GRP_2:   p = opc[5];
      GRP_3:   p = (opc[1:0] == 2'b11);
      GRP_5:   p = opc[2];
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic rb_is_pair(input logic [2:0] grp, input logic [5:0] opc);
    logic p;
    p = 1'b0;
    case (grp)
      GRP_2:   p = opc[5];
      GRP_5:   p = (opc[2:0] == 3'b111);
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic dec_bundle_t decode_word(input logic [15:0] w);
    dec_bundle_t d;
    d = '0;
    if (!w[15]) begin
      d.group  = GRP_1;
      d.opcode = 6'(w[G1_OPC_LSB +: 3]);
      d.ra     = w[G1_RA_LSB +: 4];
      d.imm    = 16'(w[7:0]);
    end else if (!w[14]) begin
      d.group  = GRP_2;
      d.opcode = w[G2_OPC_LSB +: 6];
      d.ra     = w[G2_RA_LSB +: 4];
      d.rb     = w[G2_RB_LSB +: 4];
    end else if (w[13:12] == 2'b00) begin
      d.group  = GRP_3;
      d.opcode = 6'(w[G3_OPC_LSB +: 2]);
      d.ra     = w[G3_RA_LSB +: 4];
      d.rb     = 4'(w[G3_RB_LSB +: 3]);
      d.rc     = 4'(w[G3_RC_LSB +: 3]);
    end else if (w[13:12] == 2'b01) begin
      d.group  = GRP_4;
      d.opcode = 6'(w[G4_OPC_LSB +: 4]);
      d.imm    = 16'(w[7:0]);
    end else if (w[13:10] == 4'b1000) begin
      d.group  = GRP_5;
      d.opcode = 6'(w[G5_OPC_LSB +: 3]);
      d.ra     = w[G5_RA_LSB +: 4];
      d.rb     = 4'(w[G5_RB_LSB +: 3]);
    end else begin
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
      d.illegal = 1'b1;
      d.imm     = w;
`endif
    end
    d.ra_pair = ra_is_pair(d.group, d.opcode);
    d.rb_pair = rb_is_pair(d.group, d.opcode);
    if (d.ra_pair) d.ra = d.ra >> 1;
    if (d.rb_pair) d.rb = d.rb >> 1;
    return d;
  endfunction

endpackage

// File: rtl/instr_dec_fifo.sv
// Decoded-bundle output queue; full accepts a push when a pop happens in the
// same cycle, and the head reads as zero while empty.
module instr_dec_fifo
  import pkg_instr_dec::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = dec_bundle_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic not_empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (~full | do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: decodes 16-bit words (two-word g5) into a bundle queue.
// Optional macro INSTR_DEC_ILLEGAL_TRAP_EN enqueues unknown words as illegal bundles.
module instr_decode_stage
  import pkg_instr_dec::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [15:0]          in_word,
  output logic                 in_ready,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [2:0]           dec_group,
  output logic [5:0]           dec_opcode,
  output logic [3:0]           dec_ra_index,
  output logic [3:0]           dec_rb_index,
  output logic [3:0]           dec_rc_index,
  output logic                 dec_ra_pair,
  output logic                 dec_rb_pair,
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  output logic                 dec_illegal,
`endif
  output logic [IMM_WIDTH-1:0] dec_imm
);

  localparam logic [0:0] ST_HI = 1'b0;
  localparam logic [0:0] ST_LO = 1'b1;

  logic [0:0]  state;
  logic        ready_en;
  dec_bundle_t hold;
  dec_bundle_t word_dec;
  dec_bundle_t push_data;
  dec_bundle_t head;
  logic        push;
  logic        pop;
  logic        full;
  logic        accept;

  assign word_dec = decode_word(in_word);
  assign pop      = dec_valid & dec_ready;
  assign in_ready = ready_en & ~flush & (~full | pop);
  assign accept   = in_valid & in_ready;

  // A g5 first word only parks its fields; the second word completes the bundle.
  always_comb begin
    push      = 1'b0;
    push_data = word_dec;
    if (accept) begin
      if (state == ST_LO) begin
        push          = 1'b1;
        push_data     = hold;
        push_data.imm = in_word;
      end else if (word_dec.group != GRP_5) begin
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
        push = 1'b1;
`else
        push = (word_dec.group != GRP_UNKNOWN);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HI;
      ready_en <= 1'b0;
      hold     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        state <= ST_HI;
      end else if (accept) begin
        if (state == ST_HI && word_dec.group == GRP_5) begin
          hold  <= word_dec;
          state <= ST_LO;
        end else if (state == ST_LO) begin
          state <= ST_HI;
        end
      end
    end
  end

  instr_dec_fifo #(
    .DEPTH (OUT_DEPTH),
    .T     (dec_bundle_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .not_empty (dec_valid),
    .full      (full)
  );

  assign dec_group    = head.group;
  assign dec_opcode   = head.opcode;
  assign dec_ra_index = head.ra;
  assign dec_rb_index = head.rb;
  assign dec_rc_index = head.rc;
  assign dec_ra_pair  = head.ra_pair;
  assign dec_rb_pair  = head.rb_pair;
  assign dec_imm      = IMM_WIDTH'(head.imm);
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  assign dec_illegal  = head.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: a directed vector table plus
// hand-written sequences for g5, backpressure, flush, unknown words and reset.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_group;
  logic [5:0]  dec_opcode;
  logic [3:0]  dec_ra_index;
  logic [3:0]  dec_rb_index;
  logic [3:0]  dec_rc_index;
  logic        dec_ra_pair;
  logic        dec_rb_pair;
  logic [15:0] dec_imm;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  logic        dec_illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  grp;
    logic [5:0]  opc;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        rap;
    logic        rbp;
    logic [15:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  instr_decode_stage #(
    .OUT_DEPTH (2),
    .IMM_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .in_ready     (in_ready),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_group    (dec_group),
    .dec_opcode   (dec_opcode),
    .dec_ra_index (dec_ra_index),
    .dec_rb_index (dec_rb_index),
    .dec_rc_index (dec_rc_index),
    .dec_ra_pair  (dec_ra_pair),
    .dec_rb_pair  (dec_rb_pair),
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    .dec_illegal  (dec_illegal),
`endif
    .dec_imm      (dec_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [15:0] w, input logic [2:0] g, input logic [5:0] o,
                                 input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input logic ap, input logic bp, input logic [15:0] i, input logic il);
    vec_t v;
    v.word = w; v.grp = g; v.opc = o; v.ra = a; v.rb = b; v.rc = c;
    v.rap = ap; v.rbp = bp; v.imm = i; v.ill = il;
    return v;
  endfunction

  task automatic checkSignal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [63:0] act;
    logic [63:0] exp;
    act = 64'({dec_group, dec_opcode, dec_ra_index, dec_rb_index, dec_rc_index,
               dec_ra_pair, dec_rb_pair, dec_imm});
    exp = 64'({v.grp, v.opc, v.ra, v.rb, v.rc, v.rap, v.rbp, v.imm});
    checkSignal({name, "_valid"}, 64'(dec_valid), 64'd1);
    checkSignal({name, "_fields"}, act, exp);
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    checkSignal({name, "_illegal"}, 64'(dec_illegal), 64'(v.ill));
`endif
  endtask

  // Present one word and hold it until the DUT takes it (bounded wait).
  task automatic applyStimulus(input logic [15:0] w);
    int n;
    in_word  = w;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready 0 expected 1 for word 0x%0h", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic popHead();
    dec_ready = 1'b1;
    @(posedge clk); #1;
    dec_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 16'h0000;
    dec_ready = 1'b0;

    vecs[0] = mkVec(16'h3A5F, 3'd1, 6'h03, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0, 16'h005F, 1'b0);
    vecs[1] = mkVec(16'hC29A, 3'd3, 6'h00, 4'hA, 4'h3, 4'h2, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[2] = mkVec(16'h8F4C, 3'd2, 6'h0F, 4'h4, 4'hC, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[3] = mkVec(16'hA35C, 3'd2, 6'h23, 4'h2, 4'h6, 4'h0, 1'b1, 1'b1, 16'h0000, 1'b0);
    vecs[4] = mkVec(16'hCE5B, 3'd3, 6'h03, 4'h4, 4'h3, 4'h3, 1'b1, 1'b0, 16'h0000, 1'b0);
    vecs[5] = mkVec(16'hD7A5, 3'd4, 6'h07, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h00A5, 1'b0);
    vecs[6] = mkVec(16'h0000, 3'd1, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[7] = mkVec(16'h7FFF, 3'd1, 6'h07, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 16'h00FF, 1'b0);

    // Reset state
    #12;
    checkSignal("rst_dec_valid", 64'(dec_valid), 64'd0);
    checkSignal("rst_in_ready", 64'(in_ready), 64'd0);
    checkSignal("rst_fields", 64'({dec_group, dec_opcode, dec_ra_index, dec_rb_index,
                                   dec_rc_index, dec_ra_pair, dec_rb_pair, dec_imm}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkSignal("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    checkSignal("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // Single-word vectors
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].word);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      popHead();
      checkSignal($sformatf("vec%0d_drain", i), 64'(dec_valid), 64'd0);
    end

    // g5 pair on consecutive cycles
    in_word  = 16'hE0D3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    checkSignal("g5_no_bundle_first", 64'(dec_valid), 64'd0);
    in_word = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("g5_basic", mkVec(16'h0, 3'd5, 6'h01, 4'hA, 4'h3, 4'h0, 1'b0, 1'b0, 16'h1234, 1'b0));
    popHead();
    checkSignal("g5_basic_drain", 64'(dec_valid), 64'd0);

    // g5 with both pair flags
    applyStimulus(16'hE3FF);
    checkSignal("g5p_no_bundle_first", 64'(dec_valid), 64'd0);
    applyStimulus(16'hBEEF);
    checkOutput("g5_pair", mkVec(16'h0, 3'd5, 6'h07, 4'h7, 4'h3, 4'h0, 1'b1, 1'b1, 16'hBEEF, 1'b0));
    popHead();

    // Backpressure with a full queue
    applyStimulus(16'hD100);
    applyStimulus(16'hD201);
    in_word  = 16'hD302;
    in_valid = 1'b1;
    #1;
    checkSignal("bp_full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_head0", mkVec(16'h0, 3'd4, 6'h01, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0));
    @(posedge clk); #1;
    checkSignal("bp_stall_in_ready", 64'(in_ready), 64'd0);
    checkSignal("bp_stable_opcode", 64'(dec_opcode), 64'd1);
    dec_ready = 1'b1;
    #1;
    checkSignal("bp_pop_frees_slot", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkSignal("bp_order1_opcode", 64'(dec_opcode), 64'd2);
    checkSignal("bp_order1_imm", 64'(dec_imm), 64'h01);
    @(posedge clk); #1;
    checkSignal("bp_order2_opcode", 64'(dec_opcode), 64'd3);
    checkSignal("bp_order2_imm", 64'(dec_imm), 64'h02);
    @(posedge clk); #1;
    dec_ready = 1'b0;
    checkSignal("bp_drained", 64'(dec_valid), 64'd0);

    // Flush drops a partial g5 and words presented during flush
    applyStimulus(16'hE0D3);
    checkSignal("fl_no_bundle_g5", 64'(dec_valid), 64'd0);
    flush    = 1'b1;
    in_word  = 16'hD7A5;
    in_valid = 1'b1;
    #1;
    checkSignal("fl_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkSignal("fl_nothing_queued", 64'(dec_valid), 64'd0);
    applyStimulus(16'h3A5F);
    checkOutput("fl_g1_after", vecs[0]);
    popHead();
    checkSignal("fl_single_bundle", 64'(dec_valid), 64'd0);

    // Unknown encodings
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    applyStimulus(16'hF000);
    checkOutput("unk_f000", mkVec(16'h0, 3'd0, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'hF000, 1'b1));
    popHead();
    applyStimulus(16'hE400);
    checkOutput("unk_e400", mkVec(16'h0, 3'd0, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'hE400, 1'b1));
    popHead();
`else
    applyStimulus(16'hF000);
    checkSignal("unk_f000_dropped", 64'(dec_valid), 64'd0);
    checkSignal("unk_f000_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(16'hE400);
    checkSignal("unk_e400_dropped", 64'(dec_valid), 64'd0);
`endif

    // Asynchronous reset with two queued bundles
    applyStimulus(16'hD100);
    applyStimulus(16'hD201);
    checkSignal("ar_queued", 64'(dec_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkSignal("ar_dec_valid_now", 64'(dec_valid), 64'd0);
    checkSignal("ar_in_ready_now", 64'(in_ready), 64'd0);
    checkSignal("ar_fields_now", 64'({dec_group, dec_opcode, dec_imm}), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkSignal("ar_empty_after", 64'(dec_valid), 64'd0);
    checkSignal("ar_in_ready_after", 64'(in_ready), 64'd1);

    // Reset in the middle of a g5 pair
    applyStimulus(16'hE0D3);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h3A5F);
    checkOutput("rg5_g1_after", vecs[0]);
    popHead();
    checkSignal("rg5_drain", 64'(dec_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, meaning the number of decoded-bundle entries in the output queue (power of two, 1..16).
REQ-002 SHALL have parameter IMM_WIDTH, default 16, meaning the width of dec_imm (>= 16).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all queued and partial state.
REQ-006 SHALL have port in_valid, input, 1, in_word valid.
REQ-007 SHALL have port in_word, input, 16, fetched instruction halfword.
REQ-008 SHALL have port in_ready, output, 1, word accepted when in_valid & in_ready.
REQ-009 SHALL have port dec_valid, output, 1, head bundle valid.
REQ-010 SHALL have port dec_ready, input, 1, consumer takes head when dec_valid & dec_ready.
REQ-011 SHALL have port dec_group, output, 3, group: 1..5, or 0 for unknown.
REQ-012 SHALL have port dec_opcode, output, 6, opcode zero-extended.
REQ-013 SHALL have ports dec_ra_index, dec_rb_index and dec_rc_index, output, 4 each, register indices.
REQ-014 SHALL have ports dec_ra_pair and dec_rb_pair, output, 1 each, pair flags.
REQ-015 SHALL have port dec_imm, output, IMM_WIDTH, immediate zero-extended.
REQ-016 SHALL have port dec_illegal, output, 1, unknown encoding (present only with the macro in REQ-034).

Function
REQ-017 Field extraction SHALL be:
  g1 = 0ooo aaaa iiii iiii
  g2 = 10oo oooo aaaa bbbb
  g3 = 1100 ooaa aabb bccc (rb = bbb, rc = ccc)
  g4 = 1101 oooo iiii iiii
  g5 = 1110 00oo oaaa abbb, followed by a second word iiii iiii jjjj jjjj
  Anything else is unknown.
REQ-018 Pair flags SHALL come from the shared per-group pair functions; a flagged index SHALL be the raw field shifted right by one.
REQ-019 Unused index, imm and flag fields SHALL be 0.
REQ-020 The FSM SHALL have states HI (awaiting first word) and LO (awaiting g5 second word); reset state is HI.
REQ-021 A g5 word accepted in HI SHALL latch its decoded fields and move to LO; nothing is enqueued.
REQ-022 The word accepted in LO SHALL become dec_imm[15:0], enqueue the complete bundle, and return to HI.
REQ-023 A non-g5 word accepted in HI SHALL enqueue its bundle in the same cycle.
REQ-024 Latency: dec_valid SHALL rise the cycle after the enqueueing acceptance when the queue is empty; there is no combinational path from in_word to dec outputs.
REQ-025 in_ready SHALL be low exactly when the queue holds OUT_DEPTH entries and no pop occurs this cycle (a pop frees a slot in the same cycle).
REQ-026 Bundles SHALL leave in acceptance order, and dec outputs SHALL be stable while dec_valid & !dec_ready.
REQ-027 flush SHALL empty the queue, force HI and drop any partial g5 in the next cycle; words presented during flush are discarded and in_ready is low.
REQ-028 Simultaneous enqueue and pop when full SHALL keep the count unchanged.

Reset
REQ-029 rst_n low SHALL immediately force dec_valid=0, in_ready=0, state HI, queue empty, and all dec fields 0.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset mid-g5 (in LO) SHALL discard the partial instruction.

Configuration
REQ-032 Without INSTR_DEC_ILLEGAL_TRAP_EN defined, unknown words SHALL be accepted and silently dropped.
REQ-033 Without INSTR_DEC_ILLEGAL_TRAP_EN defined, dec_illegal SHALL not exist.
REQ-034 With INSTR_DEC_ILLEGAL_TRAP_EN defined, an unknown word SHALL enqueue a bundle with dec_group=0, dec_illegal=1 and dec_imm[15:0]=the raw word.

Structure
REQ-035 Group codes, field positions, the decoded-bundle struct and the pair functions SHALL live in pkg_instr_dec.
REQ-036 The output queue SHALL be a sub-module instr_dec_fifo, parametrised by OUT_DEPTH and the bundle type.

Verification
REQ-037 OUT_DEPTH=2, queue empty; 0xE0D3 then 0x1234 on consecutive cycles -> one bundle the cycle after 0x1234: group 5, opcode 1, ra 0xA (or 0x5 if paired), rb 3, imm 0x1234; no bundle after 0xE0D3.
REQ-038 0xC29A -> group 3, opcode 0, ra 0xA (or 0x5 if paired), rb 3, rc 2, imm 0.
REQ-039 dec_ready=0; push 0xD100, 0xD201, 0xD302 -> first two accepted, in_ready low on the third; raise dec_ready -> opcodes 1, 2, 3 in order, imm 0x00, 0x01, 0x02.
REQ-040 0xE0D3 accepted, flush pulsed, then 0x3A5F -> single g1 bundle with opcode 3 and imm 0x5F; no g5 bundle.
REQ-041 0xF000 -> with macro: one bundle with dec_illegal=1, imm 0xF000; without macro: no dec_valid, in_ready stays high.
REQ-042 rst_n asserted asynchronously mid-cycle with 2 queued bundles -> dec_valid=0 before the next edge, queue empty after release.
